// File: rtl/echo_detector.sv
// echo_detector
//   Front end of the ranging path. Runs a time-since-emission counter from each
//   transmit trigger and ignores receive samples during a blanking window that
//   masks transmitter ring-down. Declares an echo after CONFIRM_COUNT
//   consecutive valid samples at or above threshold. Flags a timeout when the
//   window expires with no echo.
//
// Ports:
//   clk_in               system clock
//   rst_in               synchronous active-high reset
//   emit_start_in        single-cycle pulse at start of transmit burst
//   sample_in            unsigned receive envelope magnitude
//   sample_valid_in      qualifies sample_in
//   threshold_in         detection threshold (sampled every cycle)
//   time_since_emission  clocks since the last accepted emit_start_in
//   echo_detected        level, high from detection until next emit/reset
//   timeout_out          level, high when the window expired with no echo
//   busy_out             high in BLANK or LISTEN
//   peak_out             (ECHO_DETECTOR_PEAK_EN only) largest qualifying sample
//
// Build option: define ECHO_DETECTOR_PEAK_EN to add the peak_out port.
module echo_detector #(
  parameter int unsigned SAMPLE_WIDTH    = 12,
  parameter int unsigned BLANK_CYCLES    = 20000,
  parameter int unsigned MAX_TIME_WINDOW = 500000,
  parameter int unsigned CONFIRM_COUNT   = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    emit_start_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  input  logic [SAMPLE_WIDTH-1:0] threshold_in,
  output logic [31:0]             time_since_emission,
  output logic                    echo_detected,
  output logic                    timeout_out,
`ifdef ECHO_DETECTOR_PEAK_EN
  output logic [SAMPLE_WIDTH-1:0] peak_out,
`endif
  output logic                    busy_out
);

  localparam logic [31:0] BLANK_W   = 32'(BLANK_CYCLES);
  localparam logic [31:0] MAX_W     = 32'(MAX_TIME_WINDOW);
  localparam logic [7:0]  CONFIRM_W = 8'(CONFIRM_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    BLANK,
    LISTEN,
    DETECTED,
    TIMEOUT
  } state_t;

  state_t      state;
  logic [7:0]  confirm_cnt;
  logic [31:0] cnt_inc;
  logic [7:0]  confirm_inc;
  logic        qualify;
  logic        hit;

  always_comb begin
    cnt_inc     = (time_since_emission >= MAX_W) ? MAX_W : time_since_emission + 32'd1;
    confirm_inc = confirm_cnt + 8'd1;
    qualify     = sample_valid_in && (sample_in >= threshold_in);
    // Detection only counts on the edge that brings the run length to CONFIRM_COUNT.
    hit         = qualify && (confirm_inc == CONFIRM_W);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= IDLE;
      time_since_emission <= '0;
      confirm_cnt         <= '0;
      echo_detected       <= 1'b0;
      timeout_out         <= 1'b0;
      busy_out            <= 1'b0;
`ifdef ECHO_DETECTOR_PEAK_EN
      peak_out            <= '0;
`endif
    end else if (emit_start_in) begin
      state               <= BLANK;
      time_since_emission <= '0;
      confirm_cnt         <= '0;
      echo_detected       <= 1'b0;
      timeout_out         <= 1'b0;
      busy_out            <= 1'b1;
`ifdef ECHO_DETECTOR_PEAK_EN
      peak_out            <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          time_since_emission <= '0;
          confirm_cnt         <= '0;
          busy_out            <= 1'b0;
        end
        BLANK: begin
          time_since_emission <= cnt_inc;
          confirm_cnt         <= '0;
          if (cnt_inc == BLANK_W) begin
            state <= LISTEN;
          end
        end
        LISTEN: begin
          time_since_emission <= cnt_inc;
          if (sample_valid_in) begin
            confirm_cnt <= qualify ? confirm_inc : '0;
          end
`ifdef ECHO_DETECTOR_PEAK_EN
          if (qualify && (sample_in > peak_out)) begin
            peak_out <= sample_in;
          end
`endif
          // Detection takes precedence over a coincident window expiry.
          if (hit) begin
            echo_detected <= 1'b1;
            busy_out      <= 1'b0;
            state         <= DETECTED;
          end else if (cnt_inc == MAX_W) begin
            timeout_out <= 1'b1;
            busy_out    <= 1'b0;
            state       <= TIMEOUT;
          end
        end
        DETECTED, TIMEOUT: begin
          busy_out <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_echo_detector.sv
module tb_echo_detector;

  localparam int unsigned SW = 12;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          emit_start_in;
  logic [SW-1:0] sample_in;
  logic          sample_valid_in;
  logic [SW-1:0] threshold_in;
  logic [31:0]   time_since_emission;
  logic          echo_detected;
  logic          timeout_out;
  logic          busy_out;
`ifdef ECHO_DETECTOR_PEAK_EN
  logic [SW-1:0] peak_out;
`endif

  int checks = 0;
  int errors = 0;

  // Shortened window so the timeout path fits a short simulation.
  echo_detector #(
    .SAMPLE_WIDTH(SW),
    .BLANK_CYCLES(20),
    .MAX_TIME_WINDOW(60),
    .CONFIRM_COUNT(4)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .emit_start_in(emit_start_in),
    .sample_in(sample_in),
    .sample_valid_in(sample_valid_in),
    .threshold_in(threshold_in),
    .time_since_emission(time_since_emission),
    .echo_detected(echo_detected),
    .timeout_out(timeout_out),
`ifdef ECHO_DETECTOR_PEAK_EN
    .peak_out(peak_out),
`endif
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic emit();
    emit_start_in = 1'b1;
    tick(1);
    emit_start_in = 1'b0;
  endtask

  task automatic present(input logic [SW-1:0] s);
    sample_in       = s;
    sample_valid_in = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_in          = 1'b1;
    emit_start_in   = 1'b0;
    sample_in       = '0;
    sample_valid_in = 1'b0;
    threshold_in    = 12'd1000;
    tick(2);
    chk("rst_tse", time_since_emission, 32'd0);
    chk("rst_echo", {31'd0, echo_detected}, 32'd0);
    chk("rst_to", {31'd0, timeout_out}, 32'd0);
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    rst_in = 1'b0;
    tick(1);

    // 1: samples above threshold during BLANK are ignored
    emit();
    chk("t1_tse0", time_since_emission, 32'd0);
    chk("t1_busy", {31'd0, busy_out}, 32'd1);
    sample_in = 12'd2000;
    sample_valid_in = 1'b1;
    tick(19);
    chk("t1_tse19", time_since_emission, 32'd19);
    chk("t1_blank_echo", {31'd0, echo_detected}, 32'd0);
    tick(1);   // counter 20 -> LISTEN; four qualifying samples at 20..23
    tick(3);
    chk("t1_echo_pre", {31'd0, echo_detected}, 32'd0);
    tick(1);
    chk("t1_echo", {31'd0, echo_detected}, 32'd1);
    chk("t1_tse_det", time_since_emission, 32'd24);
    sample_valid_in = 1'b0;
    tick(5);
    chk("t1_tse_frozen", time_since_emission, 32'd24);
    chk("t1_busy_det", {31'd0, busy_out}, 32'd0);

    // 2: re-emit drops echo; a below-threshold sample restarts the run,
    //    a non-valid cycle leaves it untouched
    emit();
    chk("t2_echo_drop", {31'd0, echo_detected}, 32'd0);
    chk("t2_tse0", time_since_emission, 32'd0);
    tick(20);
    present(12'd2000);
    present(12'd2000);
    present(12'd2000);
    present(12'd500);
    present(12'd2000);
    present(12'd2000);
    sample_valid_in = 1'b0;
    sample_in = 12'd0;
    tick(1);
    present(12'd2000);
    chk("t2_echo_pre", {31'd0, echo_detected}, 32'd0);
    present(12'd2000);
    sample_valid_in = 1'b0;
    chk("t2_echo", {31'd0, echo_detected}, 32'd1);
    chk("t2_tse_det", time_since_emission, 32'd29);

    // 3: nothing reaches threshold -> timeout at the window end
    emit();
    sample_in = 12'd500;
    sample_valid_in = 1'b1;
    tick(59);
    chk("t3_tse59", time_since_emission, 32'd59);
    chk("t3_to_pre", {31'd0, timeout_out}, 32'd0);
    chk("t3_busy_pre", {31'd0, busy_out}, 32'd1);
    tick(1);
    chk("t3_to", {31'd0, timeout_out}, 32'd1);
    chk("t3_tse_max", time_since_emission, 32'd60);
    chk("t3_echo", {31'd0, echo_detected}, 32'd0);
    chk("t3_busy", {31'd0, busy_out}, 32'd0);
    tick(3);
    chk("t3_tse_hold", time_since_emission, 32'd60);
    chk("t3_to_hold", {31'd0, timeout_out}, 32'd1);

    // 4: 4th qualifying sample on the edge the window expires -> detection wins
    sample_valid_in = 1'b0;
    emit();
    tick(56);
    present(12'd1200);
    present(12'd3000);
    present(12'd1500);
    chk("t4_tse59", time_since_emission, 32'd59);
    chk("t4_echo_pre", {31'd0, echo_detected}, 32'd0);
    present(12'd1100);
    sample_valid_in = 1'b0;
    chk("t4_echo", {31'd0, echo_detected}, 32'd1);
    chk("t4_to", {31'd0, timeout_out}, 32'd0);
    chk("t4_tse", time_since_emission, 32'd60);
`ifdef ECHO_DETECTOR_PEAK_EN
    chk("t4_peak", {20'd0, peak_out}, 32'd3000);
`endif

    // 5: reset mid-LISTEN discards the measurement
    emit();
    tick(25);
    present(12'd2000);
    present(12'd2000);
    chk("t5_busy", {31'd0, busy_out}, 32'd1);
    sample_valid_in = 1'b0;
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    chk("t5_tse", time_since_emission, 32'd0);
    chk("t5_echo", {31'd0, echo_detected}, 32'd0);
    chk("t5_to", {31'd0, timeout_out}, 32'd0);
    chk("t5_busy_rst", {31'd0, busy_out}, 32'd0);
`ifdef ECHO_DETECTOR_PEAK_EN
    chk("t5_peak", {20'd0, peak_out}, 32'd0);
`endif
    // IDLE ignores samples and keeps the counter at zero
    present(12'd2000);
    present(12'd2000);
    present(12'd2000);
    present(12'd2000);
    sample_valid_in = 1'b0;
    tick(2);
    chk("t5_idle_echo", {31'd0, echo_detected}, 32'd0);
    chk("t5_idle_tse", time_since_emission, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
